store_buffer: RTL and testbench

Word-granular posted-write buffer between the MEM stage of the 32-bit pipelined MIPS core and the single-port data memory. Stores retire into a small FIFO and drain to memory in cycles when no load needs the port, and loads forward from the youngest matching buffered store. It owns the data-memory address/control lines and the pipeline stall request for memory-port conflicts.

---
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: word-granular posted-write buffer between the MEM stage and a
// single-port data memory. Stores queue in a small circular FIFO and drain when
// no load needs the port. Loads forward from the youngest matching queued store.
// When the FIFO is full, the head drains unconditionally and the pipeline stalls.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_valid,
  input  logic [AW-1:0]             st_addr,
  input  logic [DW-1:0]             st_data,
  input  logic                      ld_valid,
  input  logic [AW-1:0]             ld_addr,
  output logic [DW-1:0]             ld_data,
  output logic                      stall,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  output logic                      mem_read,
  output logic                      mem_write,
  input  logic [DW-1:0]             mem_rdata,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0]  addr_q  [DEPTH];
  logic [DW-1:0]  data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;

  logic           full;
  logic           enq;
  logic           drain;
  logic           fwd_hit;
  logic [DW-1:0]  fwd_data;
  logic [PW-1:0]  fwd_idx;

  // Byte-offset bits are meaningless for word accesses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign full  = (count_q == CW'(DEPTH));
  assign enq   = st_valid && !full;
  assign drain = full || (!ld_valid && (count_q != '0));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Youngest matching entry wins: scan from oldest to youngest, later hits override.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Memory port arbitration: full-drain, then load, then opportunistic drain.
  always_comb begin
    stall     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ld_data   = '0;
    if (full) begin
      mem_write = 1'b1;
      mem_addr  = {addr_q[head_q], 2'b00};
      mem_wdata = data_q[head_q];
      stall     = st_valid || ld_valid;
    end else if (ld_valid) begin
      mem_read  = 1'b1;
      mem_addr  = {ld_addr[AW-1:2], 2'b00};
      ld_data   = fwd_hit ? fwd_data : mem_rdata;
    end else if (count_q != '0) begin
      mem_write = 1'b1;
      mem_addr  = {addr_q[head_q], 2'b00};
      mem_wdata = data_q[head_q];
    end
  end

  // FIFO control: pointers, occupancy and entry-valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (enq && !drain)
        count_q <= count_q + 1'b1;
      else if (drain && !enq)
        count_q <= count_q - 1'b1;
    end
  end

  // Entry payload: written at the tail on enqueue; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr[AW-1:2];
      data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based model of
// the posted-write buffer plus a word-array model of data memory.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory driven by the DUT, and the reference memory from the model.
  logic [31:0] tbmem  [16];
  logic [31:0] refmem [16];
  assign mem_rdata = tbmem[mem_addr[5:2]];

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0;
      st_addr = '0; st_data = '0; ld_addr = '0;
      if (i >= 1) begin
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
      end
      @(posedge clk);
      q.delete();
    end
    last_stall = 1'b0;
  endtask

  // One pipeline cycle: drive, check against the model, then advance at the edge.
  task automatic cycle(input logic s, input logic [5:0] sa, input logic [31:0] sd,
                       input logic l, input logic [5:0] la);
    logic        full, exp_drain, wr;
    logic [31:0] exp_ld, wa, wd;
    @(negedge clk);
    rst = 1'b0;
    st_valid = s; st_addr = {26'd0, sa}; st_data = sd;
    ld_valid = l; ld_addr = {26'd0, la};
    #1;
    full      = (q.size() == DEPTH);
    exp_drain = full || (!l && q.size() > 0);
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("stall", 32'(stall), 32'(full && (s || l)));
    chk("mem_write", 32'(mem_write), 32'(exp_drain));
    chk("mem_read", 32'(mem_read), 32'(!full && l));
    if (exp_drain) begin
      chk("drain_addr", mem_addr, {26'd0, q[0].a, 2'b00});
      chk("drain_wdata", mem_wdata, q[0].d);
    end else if (l) begin
      chk("load_addr", mem_addr, {26'd0, la[5:2], 2'b00});
    end else begin
      chk("idle_addr", mem_addr, 32'd0);
      chk("idle_wdata", mem_wdata, 32'd0);
    end
    exp_ld = 32'd0;
    if (l && !full) begin
      exp_ld = refmem[la[5:2]];
      foreach (q[i]) if (q[i].a == la[5:2]) exp_ld = q[i].d;
    end
    chk("ld_data", ld_data, exp_ld);
    last_stall = stall;
    wr = mem_write; wa = mem_addr; wd = mem_wdata;
    @(posedge clk);
    if (wr) tbmem[wa[5:2]] = wd;
    if (exp_drain) begin
      refmem[q[0].a] = q[0].d;
      void'(q.pop_front());
    end
    if (s && !full) q.push_back('{a: sa[5:2], d: sd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, tbmem[i], refmem[i]);
  endtask

  logic        rs, rl;
  logic [5:0]  rsa, rla;
  logic [31:0] rsd;

  initial begin
    rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    for (int i = 0; i < 16; i++) begin
      tbmem[i]  = $urandom;
      refmem[i] = tbmem[i];
    end

    apply_reset(2);

    // Basic drain
    cycle(1'b1, 6'h28, 32'h76, 1'b0, 6'h0);
    idle(2);
    chk("drain_mem28", tbmem[10], 32'h76);

    // Forwarding over stale memory contents
    tbmem[9] = 32'h12; refmem[9] = 32'h12;
    cycle(1'b1, 6'h24, 32'hAA, 1'b0, 6'h0);
    cycle(1'b0, 6'h0, 32'h0, 1'b1, 6'h24);
    idle(2);
    chk("fwd_mem24", tbmem[9], 32'hAA);

    // Youngest matching store wins; both drain in order
    cycle(1'b1, 6'h24, 32'h1, 1'b1, 6'h30);
    cycle(1'b1, 6'h24, 32'h2, 1'b1, 6'h30);
    cycle(1'b0, 6'h0, 32'h0, 1'b1, 6'h24);
    idle(3);
    chk("young_mem24", tbmem[9], 32'h2);

    // Full stall, held request proceeds next cycle
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i * 4), 32'(100 + i), 1'b1, 6'h30);
    cycle(1'b1, 6'h10, 32'h55, 1'b1, 6'h30);
    cycle(1'b1, 6'h10, 32'h55, 1'b1, 6'h30);
    idle(6);
    check_mem("full_mem");

    // Reset with three pending stores discards them
    cycle(1'b1, 6'h34, 32'hDEAD0001, 1'b1, 6'h0);
    cycle(1'b1, 6'h38, 32'hDEAD0002, 1'b1, 6'h0);
    cycle(1'b1, 6'h3C, 32'hDEAD0003, 1'b1, 6'h0);
    apply_reset(1);
    idle(4);
    check_mem("midrst_mem");

    // Random traffic; a stalled request is held unchanged for the next cycle
    rs = 1'b0; rl = 1'b0; rsa = '0; rla = '0; rsd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        rs  = ($urandom_range(0, 99) < 55);
        rl  = ($urandom_range(0, 99) < 60);
        rsa = 6'($urandom_range(0, 7) * 4);
        rla = 6'($urandom_range(0, 7) * 4);
        rsd = $urandom;
      end
      cycle(rs, rsa, rsd, rl, rla);
    end
    idle(DEPTH + 2);
    check_mem("rand_mem");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
